item_mem_arbiter: RTL and testbench

//  Serialises all accesses to the single-port 32-bit item RAM (sync read, 1-cycle latency).

---
 rtl/item_mem_pkg.sv | 39 +++
 rtl/item_mem_grant.sv | 63 ++++++
 rtl/item_mem_arbiter.sv | 213 +++++++++++++++++++++
 tb/tb_item_mem_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/item_mem_pkg.sv
// Shared definitions for the item RAM arbiter: word field positions, requester
// indices, FSM state encoding and the dispense read-modify-write helper.
package item_mem_pkg;

    localparam int COST_LSB  = 0;
    localparam int COST_MSB  = 15;
    localparam int AVAIL_LSB = 16;
    localparam int AVAIL_MSB = 23;
    localparam int DISP_LSB  = 24;
    localparam int DISP_MSB  = 31;

    // Requester indices; lower index wins in normal arbitration
    localparam int REQ_UPD = 0;
    localparam int REQ_FRD = 1;
    localparam int REQ_CWR = 2;
    localparam int REQ_CRD = 3;
    localparam int NUM_REQ = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RD     = 2'd1,
        ST_UPD_RD = 2'd2,
        ST_UPD_WR = 2'd3
    } state_e;

    // One item leaves stock: available drops by one, dispensed saturates at 0xFF
    function automatic logic [31:0] dispense_word(input logic [31:0] w);
        logic [7:0] avail_v;
        logic [7:0] disp_v;
        avail_v = w[AVAIL_MSB:AVAIL_LSB] - 8'd1;
        if (w[DISP_MSB:DISP_LSB] == 8'hFF) begin
            disp_v = 8'hFF;
        end else begin
            disp_v = w[DISP_MSB:DISP_LSB] + 8'd1;
        end
        return {disp_v, avail_v, w[COST_MSB:COST_LSB]};
    endfunction

endpackage

// File: rtl/item_mem_grant.sv
// Fixed-priority arbiter with a starvation counter that forces a config grant
// after STARVE_LIMIT consecutive FSM grants while config traffic waits.
module item_mem_grant
    import item_mem_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic               clk_fsm,
    input  logic               rstn,
    input  logic               arb_en,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] elig,
    output logic [NUM_REQ-1:0] gnt
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic [CW-1:0]      cnt_q, cnt_d;
    logic [NUM_REQ-1:0] ok_s;
    logic               cfg_pend_s;
    logic               starve_s;

    // Grant selection and starvation counter next value
    always_comb begin
        ok_s       = req & elig & {NUM_REQ{arb_en}};
        cfg_pend_s = req[REQ_CWR] | req[REQ_CRD];
        starve_s   = (cnt_q == CW'(STARVE_LIMIT));
        gnt        = '0;
        if (starve_s && ok_s[REQ_CWR]) begin
            gnt[REQ_CWR] = 1'b1;
        end else if (starve_s && ok_s[REQ_CRD]) begin
            gnt[REQ_CRD] = 1'b1;
        end else if (ok_s[REQ_UPD]) begin
            gnt[REQ_UPD] = 1'b1;
        end else if (ok_s[REQ_FRD]) begin
            gnt[REQ_FRD] = 1'b1;
        end else if (ok_s[REQ_CWR]) begin
            gnt[REQ_CWR] = 1'b1;
        end else if (ok_s[REQ_CRD]) begin
            gnt[REQ_CRD] = 1'b1;
        end else begin
            gnt = '0;
        end

        if (!cfg_pend_s || gnt[REQ_CWR] || gnt[REQ_CRD]) begin
            cnt_d = '0;
        end else if ((gnt[REQ_UPD] || gnt[REQ_FRD]) && !starve_s) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Starvation counter register
    always_ff @(posedge clk_fsm or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/item_mem_arbiter.sv
// Serialises FSM item reads, FSM dispense updates and config reads/writes onto
// the single-port item RAM; state machine, RMW datapath and output registers.
module item_mem_arbiter
    import item_mem_pkg::*;
#(
    parameter int MAX_ITEMS    = 1024,
    parameter int ADDR_WIDTH   = 10,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk_fsm,
    input  logic                  rstn,
    input  logic                  fsm_read_req,
    input  logic [ADDR_WIDTH-1:0] fsm_read_addr,
    output logic [15:0]           fsm_item_cost,
    output logic [7:0]            fsm_item_available,
    output logic                  fsm_data_valid,
    input  logic                  fsm_update_req,
    input  logic [ADDR_WIDTH-1:0] fsm_update_addr,
    output logic                  fsm_update_done,
    output logic                  fsm_update_err,
    input  logic                  cfg_read_req,
    input  logic [ADDR_WIDTH-1:0] cfg_read_addr,
    output logic [31:0]           cfg_read_data,
    output logic                  cfg_read_valid,
    input  logic                  cfg_write_req,
    input  logic [ADDR_WIDTH-1:0] cfg_write_addr,
    input  logic [31:0]           cfg_write_data,
    output logic                  cfg_write_done,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata,
    output logic                  busy
);

    state_e                state_q, state_d;
    logic                  rd_cfg_q, rd_cfg_d;
    logic [ADDR_WIDTH-1:0] upd_addr_q, upd_addr_d;
    logic [31:0]           word_q, word_d;
    logic [15:0]           cost_q, cost_d;
    logic [7:0]            avail_q, avail_d;
    logic [31:0]           cfg_data_q, cfg_data_d;
    logic                  frd_valid_q, frd_valid_d;
    logic                  upd_done_q, upd_done_d;
    logic                  upd_err_q, upd_err_d;
    logic                  crd_valid_q, crd_valid_d;
    logic                  cwr_done_q, cwr_done_d;
    logic [NUM_REQ-1:0]    req_s, elig_s, gnt_s;
    logic                  arb_en_s;

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return 32'(a) < 32'(MAX_ITEMS);
    endfunction

    assign req_s    = {cfg_read_req, cfg_write_req, fsm_read_req, fsm_update_req};
    // A port whose completion pulse is showing cannot be granted again this cycle
    assign elig_s   = ~{crd_valid_q, cwr_done_q, frd_valid_q, upd_done_q};
    assign arb_en_s = (state_q == ST_IDLE) && rstn;

    item_mem_grant #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_grant (
        .clk_fsm (clk_fsm),
        .rstn    (rstn),
        .arb_en  (arb_en_s),
        .req     (req_s),
        .elig    (elig_s),
        .gnt     (gnt_s)
    );

    // Next state, RAM strobes and completion outputs
    always_comb begin
        state_d     = state_q;
        rd_cfg_d    = rd_cfg_q;
        upd_addr_d  = upd_addr_q;
        word_d      = word_q;
        cost_d      = cost_q;
        avail_d     = avail_q;
        cfg_data_d  = cfg_data_q;
        frd_valid_d = 1'b0;
        upd_done_d  = 1'b0;
        upd_err_d   = 1'b0;
        crd_valid_d = 1'b0;
        cwr_done_d  = 1'b0;
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = 32'd0;
        case (state_q)
            ST_IDLE: begin
                if (gnt_s[REQ_UPD]) begin
                    if (in_range(fsm_update_addr)) begin
                        mem_en     = 1'b1;
                        mem_addr   = fsm_update_addr;
                        upd_addr_d = fsm_update_addr;
                        state_d    = ST_UPD_RD;
                    end else begin
                        upd_done_d = 1'b1;
                        upd_err_d  = 1'b1;
                    end
                end else if (gnt_s[REQ_FRD]) begin
                    if (in_range(fsm_read_addr)) begin
                        mem_en   = 1'b1;
                        mem_addr = fsm_read_addr;
                        rd_cfg_d = 1'b0;
                        state_d  = ST_RD;
                    end else begin
                        frd_valid_d = 1'b1;
                        cost_d      = 16'd0;
                        avail_d     = 8'd0;
                    end
                end else if (gnt_s[REQ_CWR]) begin
                    if (in_range(cfg_write_addr)) begin
                        mem_en    = 1'b1;
                        mem_we    = 1'b1;
                        mem_addr  = cfg_write_addr;
                        mem_wdata = cfg_write_data;
                    end else begin
                        mem_en = 1'b0;
                    end
                    cwr_done_d = 1'b1;
                end else if (gnt_s[REQ_CRD]) begin
                    if (in_range(cfg_read_addr)) begin
                        mem_en   = 1'b1;
                        mem_addr = cfg_read_addr;
                        rd_cfg_d = 1'b1;
                        state_d  = ST_RD;
                    end else begin
                        crd_valid_d = 1'b1;
                        cfg_data_d  = 32'd0;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD: begin
                if (rd_cfg_q) begin
                    cfg_data_d  = mem_rdata;
                    crd_valid_d = 1'b1;
                end else begin
                    cost_d      = mem_rdata[COST_MSB:COST_LSB];
                    avail_d     = mem_rdata[AVAIL_MSB:AVAIL_LSB];
                    frd_valid_d = 1'b1;
                end
                state_d = ST_IDLE;
            end
            ST_UPD_RD: begin
                word_d = mem_rdata;
                if (mem_rdata[AVAIL_MSB:AVAIL_LSB] == 8'd0) begin
                    upd_done_d = 1'b1;
                    upd_err_d  = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    state_d = ST_UPD_WR;
                end
            end
            ST_UPD_WR: begin
                mem_en     = 1'b1;
                mem_we     = 1'b1;
                mem_addr   = upd_addr_q;
                mem_wdata  = dispense_word(word_q);
                upd_done_d = 1'b1;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk_fsm or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            rd_cfg_q    <= 1'b0;
            upd_addr_q  <= '0;
            word_q      <= 32'd0;
            cost_q      <= 16'd0;
            avail_q     <= 8'd0;
            cfg_data_q  <= 32'd0;
            frd_valid_q <= 1'b0;
            upd_done_q  <= 1'b0;
            upd_err_q   <= 1'b0;
            crd_valid_q <= 1'b0;
            cwr_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_cfg_q    <= rd_cfg_d;
            upd_addr_q  <= upd_addr_d;
            word_q      <= word_d;
            cost_q      <= cost_d;
            avail_q     <= avail_d;
            cfg_data_q  <= cfg_data_d;
            frd_valid_q <= frd_valid_d;
            upd_done_q  <= upd_done_d;
            upd_err_q   <= upd_err_d;
            crd_valid_q <= crd_valid_d;
            cwr_done_q  <= cwr_done_d;
        end
    end

    assign fsm_item_cost      = cost_q;
    assign fsm_item_available = avail_q;
    assign fsm_data_valid     = frd_valid_q;
    assign fsm_update_done    = upd_done_q;
    assign fsm_update_err     = upd_err_q;
    assign cfg_read_data      = cfg_data_q;
    assign cfg_read_valid     = crd_valid_q;
    assign cfg_write_done     = cwr_done_q;
    assign busy               = (state_q != ST_IDLE);

endmodule

// File: tb/tb_item_mem_arbiter.sv
// Directed bench for item_mem_arbiter with a behavioural single-port RAM.
module tb_item_mem_arbiter;

    localparam int AW = 10;

    logic          clk_fsm = 1'b0;
    logic          rstn;
    logic          fsm_read_req, fsm_update_req, cfg_read_req, cfg_write_req;
    logic [AW-1:0] fsm_read_addr, fsm_update_addr, cfg_read_addr, cfg_write_addr;
    logic [31:0]   cfg_write_data;
    logic [15:0]   fsm_item_cost;
    logic [7:0]    fsm_item_available;
    logic          fsm_data_valid, fsm_update_done, fsm_update_err;
    logic [31:0]   cfg_read_data;
    logic          cfg_read_valid, cfg_write_done;
    logic          mem_en, mem_we, busy;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata = 32'd0;

    int checks = 0;
    int errors = 0;

    always #5 clk_fsm = ~clk_fsm;

    item_mem_arbiter #(
        .MAX_ITEMS    (1000),
        .ADDR_WIDTH   (AW),
        .STARVE_LIMIT (4)
    ) dut (
        .clk_fsm            (clk_fsm),
        .rstn               (rstn),
        .fsm_read_req       (fsm_read_req),
        .fsm_read_addr      (fsm_read_addr),
        .fsm_item_cost      (fsm_item_cost),
        .fsm_item_available (fsm_item_available),
        .fsm_data_valid     (fsm_data_valid),
        .fsm_update_req     (fsm_update_req),
        .fsm_update_addr    (fsm_update_addr),
        .fsm_update_done    (fsm_update_done),
        .fsm_update_err     (fsm_update_err),
        .cfg_read_req       (cfg_read_req),
        .cfg_read_addr      (cfg_read_addr),
        .cfg_read_data      (cfg_read_data),
        .cfg_read_valid     (cfg_read_valid),
        .cfg_write_req      (cfg_write_req),
        .cfg_write_addr     (cfg_write_addr),
        .cfg_write_data     (cfg_write_data),
        .cfg_write_done     (cfg_write_done),
        .mem_en             (mem_en),
        .mem_we             (mem_we),
        .mem_addr           (mem_addr),
        .mem_wdata          (mem_wdata),
        .mem_rdata          (mem_rdata),
        .busy               (busy)
    );

    // Behavioural RAM with a bench-side preload port
    logic [31:0]   ram [0:1023];
    logic          pl_en = 1'b0;
    logic [AW-1:0] pl_addr = '0;
    logic [31:0]   pl_data = 32'd0;
    int            we_cnt = 0;

    always @(posedge clk_fsm) begin
        if (pl_en) begin
            ram[pl_addr] <= pl_data;
        end else if (mem_en) begin
            if (mem_we) begin
                ram[mem_addr] <= mem_wdata;
                we_cnt <= we_cnt + 1;
            end else begin
                mem_rdata <= ram[mem_addr];
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [31:0] d);
        @(negedge clk_fsm);
        pl_addr = a;
        pl_data = d;
        pl_en   = 1'b1;
        @(negedge clk_fsm);
        pl_en   = 1'b0;
    endtask

    task automatic run_fsm_read(input logic [AW-1:0] a, input int lat, input logic [15:0] ec,
                                input logic [7:0] ea, input logic een);
        int n = 0;
        @(negedge clk_fsm);
        fsm_read_addr = a;
        fsm_read_req  = 1'b1;
        #1;
        check_eq("frd_grant_en", {31'd0, mem_en}, {31'd0, een});
        do begin @(negedge clk_fsm); n++; end while (!fsm_data_valid && n < 20);
        fsm_read_req = 1'b0;
        check_eq("frd_latency", n, lat);
        check_eq("frd_cost", {16'd0, fsm_item_cost}, {16'd0, ec});
        check_eq("frd_avail", {24'd0, fsm_item_available}, {24'd0, ea});
    endtask

    task automatic run_update(input logic [AW-1:0] a, input int lat, input logic eerr, input int ewe);
        int n = 0;
        int we0 = we_cnt;
        @(negedge clk_fsm);
        fsm_update_addr = a;
        fsm_update_req  = 1'b1;
        do begin @(negedge clk_fsm); n++; end while (!fsm_update_done && n < 20);
        fsm_update_req = 1'b0;
        check_eq("upd_latency", n, lat);
        check_eq("upd_err", {31'd0, fsm_update_err}, {31'd0, eerr});
        check_eq("upd_writes", we_cnt - we0, ewe);
    endtask

    task automatic run_cfg_read(input logic [AW-1:0] a, input int lat, input logic [31:0] ed);
        int n = 0;
        @(negedge clk_fsm);
        cfg_read_addr = a;
        cfg_read_req  = 1'b1;
        do begin @(negedge clk_fsm); n++; end while (!cfg_read_valid && n < 20);
        cfg_read_req = 1'b0;
        check_eq("crd_latency", n, lat);
        check_eq("crd_data", cfg_read_data, ed);
    endtask

    task automatic run_cfg_write(input logic [AW-1:0] a, input logic [31:0] d, input int lat, input int ewe);
        int n = 0;
        int we0 = we_cnt;
        @(negedge clk_fsm);
        cfg_write_addr = a;
        cfg_write_data = d;
        cfg_write_req  = 1'b1;
        #1;
        check_eq("cwr_grant_we", {31'd0, mem_we}, {31'd0, (ewe != 0)});
        do begin @(negedge clk_fsm); n++; end while (!cfg_write_done && n < 20);
        cfg_write_req = 1'b0;
        check_eq("cwr_latency", n, lat);
        check_eq("cwr_writes", we_cnt - we0, ewe);
    endtask

    initial begin
        int n;
        int comp;
        int ud;
        int cd;
        int we0;
        logic uerr;

        rstn = 1'b0;
        {fsm_read_req, fsm_update_req, cfg_read_req, cfg_write_req} = 4'd0;
        fsm_read_addr = '0; fsm_update_addr = '0; cfg_read_addr = '0; cfg_write_addr = '0;
        cfg_write_data = 32'd0;
        repeat (3) @(negedge clk_fsm);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_mem", {30'd0, mem_en, mem_we}, 32'd0);
        check_eq("rst_pulses", {27'd0, fsm_data_valid, fsm_update_done, fsm_update_err,
                                cfg_read_valid, cfg_write_done}, 32'd0);
        check_eq("rst_data", cfg_read_data | {16'd0, fsm_item_cost} | {24'd0, fsm_item_available}, 32'd0);
        rstn = 1'b1;

        preload(10'd5,  32'h0003_0A32);
        preload(10'd7,  32'h0000_0A00);
        preload(10'd9,  32'hFF05_1234);
        preload(10'd20, 32'h0010_0000);
        preload(10'd21, 32'h0007_0BB8);
        preload(10'd30, 32'h0005_0000);
        preload(10'd40, 32'h0002_0000);

        // Basic reads and dispense updates
        run_fsm_read(10'd5, 2, 16'h0A32, 8'h03, 1'b1);
        repeat (3) @(negedge clk_fsm);
        check_eq("frd_hold", {16'd0, fsm_item_cost}, 32'h0000_0A32);
        run_update(10'd5, 3, 1'b0, 1);
        check_eq("upd5_word", ram[5], 32'h0102_0A32);
        run_update(10'd7, 2, 1'b1, 0);
        run_cfg_read(10'd7, 2, 32'h0000_0A00);
        run_update(10'd9, 3, 1'b0, 1);
        check_eq("upd9_sat", ram[9], 32'hFF04_1234);
        run_cfg_write(10'd3, 32'hDEAD_BEEF, 1, 1);
        check_eq("cwr3_word", ram[3], 32'hDEAD_BEEF);
        run_cfg_read(10'd3, 2, 32'hDEAD_BEEF);

        // Out-of-range addresses complete one cycle after grant without RAM access
        run_fsm_read(10'd1000, 1, 16'h0000, 8'h00, 1'b0);
        run_update(10'd1010, 1, 1'b1, 0);
        run_cfg_read(10'd1023, 1, 32'h0000_0000);
        run_cfg_write(10'd1000, 32'h1111_2222, 1, 0);

        // Starvation: FSM update and read alternate while cfg write waits
        @(negedge clk_fsm);
        fsm_update_addr = 10'd20;
        fsm_read_addr   = 10'd21;
        cfg_write_addr  = 10'd22;
        cfg_write_data  = 32'h1234_5678;
        {fsm_update_req, fsm_read_req, cfg_write_req} = 3'b111;
        n = 0; comp = 0;
        do begin
            @(negedge clk_fsm);
            n++;
            if (fsm_data_valid || fsm_update_done) comp++;
        end while (!cfg_write_done && n < 100);
        {fsm_update_req, fsm_read_req, cfg_write_req} = 3'b000;
        check_eq("starve_done_seen", {31'd0, cfg_write_done}, 32'd1);
        check_eq("starve_fsm_before_cfg", comp, 4);
        check_eq("starve_cwr_word", ram[22], 32'h1234_5678);
        n = 0;
        while (busy && n < 20) begin @(negedge clk_fsm); n++; end
        @(negedge clk_fsm);
        check_eq("starve_upd_word", ram[20], 32'h020E_0000);

        // Update and cfg write to the same address in the same cycle
        @(negedge clk_fsm);
        fsm_update_addr = 10'd30;
        cfg_write_addr  = 10'd30;
        cfg_write_data  = 32'hCAFE_0001;
        {fsm_update_req, cfg_write_req} = 2'b11;
        n = 0; ud = 0; cd = 0; uerr = 1'b1;
        do begin
            @(negedge clk_fsm);
            n++;
            if (fsm_update_done) begin ud = n; uerr = fsm_update_err; fsm_update_req = 1'b0; end
            if (cfg_write_done) begin cd = n; cfg_write_req = 1'b0; end
        end while ((ud == 0 || cd == 0) && n < 50);
        {fsm_update_req, cfg_write_req} = 2'b00;
        check_eq("same_upd_latency", ud, 3);
        check_eq("same_cwr_latency", cd, 4);
        check_eq("same_upd_err", {31'd0, uerr}, 32'd0);
        run_cfg_read(10'd30, 2, 32'hCAFE_0001);

        // Reset in UPD_RD aborts the update; reissue completes normally
        @(negedge clk_fsm);
        we0 = we_cnt;
        fsm_update_addr = 10'd40;
        fsm_update_req  = 1'b1;
        @(negedge clk_fsm);
        check_eq("abort_busy_before", {31'd0, busy}, 32'd1);
        rstn = 1'b0;
        #1;
        check_eq("abort_outputs", {28'd0, busy, mem_en, mem_we, fsm_update_done}, 32'd0);
        @(negedge clk_fsm);
        check_eq("abort_mem_en_held", {31'd0, mem_en}, 32'd0);
        check_eq("abort_no_write", we_cnt - we0, 0);
        check_eq("abort_word", ram[40], 32'h0002_0000);
        rstn = 1'b1;
        n = 0;
        do begin @(negedge clk_fsm); n++; end while (!fsm_update_done && n < 20);
        fsm_update_req = 1'b0;
        check_eq("reissue_latency", n, 3);
        check_eq("reissue_err", {31'd0, fsm_update_err}, 32'd0);
        check_eq("reissue_word", ram[40], 32'h0101_0000);

        repeat (2) @(negedge clk_fsm);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
